pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).
//  - Detects load-use hazards on ID operands.
//  - Sequences the multi-cycle mul/div unit sitting in EX.
//  - Flushes wrong-path instructions when EX resolves a redirect (branch taken, JAL, JALR).
//  - Keeps stall/flush performance counters.

---
 rtl/pipe_hazard_ctrl_if.sv | 42 ++++
 rtl/pipe_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard-control bus between the pipeline datapath and pipe_hazard_ctrl.
//   master : datapath side; drives ID/EX hazard information and md_done,
//            receives the stall/flush/bubble controls and the status/counters.
//   slave  : pipe_hazard_ctrl side.
// CNT_W sets the width of the stall_cnt / flush_cnt performance counters.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd;
    logic             ex_memread;
    logic             ex_redirect;
    logic             ex_md_valid;
    logic             md_done;
    logic             pc_stall;
    logic             ifid_stall;
    logic             idex_stall;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_bubble;
    logic             md_start;
    logic             md_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
               ex_redirect, ex_md_valid, md_done,
        input  pc_stall, ifid_stall, idex_stall, ifid_flush, idex_flush,
               exmem_bubble, md_start, md_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
               ex_redirect, ex_md_valid, md_done,
        output pc_stall, ifid_stall, idex_stall, ifid_flush, idex_flush,
               exmem_bubble, md_start, md_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32 pipeline.
//   - Load-use hazard detection on the ID operands (one bubble per hazard).
//   - Sequencing of the multi-cycle mul/div unit in EX, with timeout abort.
//   - Wrong-path flush when EX resolves a PC redirect.
//   - Saturating stall/flush performance counters.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : pipe_hazard_ctrl_if.slave (hazard inputs, control outputs,
//           sticky md_err, stall_cnt / flush_cnt)
// Control outputs are combinational from state and inputs and forced to 0
// while reset is asserted.
module pipe_hazard_ctrl #(
    parameter int unsigned MD_TIMEOUT = 32,
    parameter int unsigned CNT_W      = 32
) (
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  bus
);
    localparam int unsigned            MD_CNT_W = $clog2(MD_TIMEOUT);
    localparam logic [MD_CNT_W-1:0]    MD_LAST  = MD_CNT_W'(MD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_WAIT  = 2'd1,
        MD_ABORT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic                md_err_q, md_err_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

    logic lu;
    logic pc_stall, ifid_stall, idex_stall;
    logic ifid_flush, idex_flush, exmem_bubble, md_start;

    assign lu = bus.ex_memread && (bus.ex_rd != 5'd0) &&
                ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                 (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

    always_comb begin
        state_d      = state_q;
        md_cnt_d     = md_cnt_q;
        md_err_d     = md_err_q;
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        idex_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;
        md_start     = 1'b0;

        case (state_q)
            RUN: begin
                if (bus.ex_md_valid) begin
                    md_start     = 1'b1;
                    pc_stall     = 1'b1;
                    ifid_stall   = 1'b1;
                    idex_stall   = 1'b1;
                    exmem_bubble = 1'b1;
                    state_d      = MD_WAIT;
                    md_cnt_d     = MD_CNT_W'(1);
                end else if (bus.ex_redirect) begin
                    // ID holds a wrong-path instruction, so any load-use on it is moot.
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (lu) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                end
            end
            MD_WAIT: begin
                if (bus.md_done) begin
                    state_d  = RUN;
                    md_cnt_d = '0;
                end else begin
                    pc_stall     = 1'b1;
                    ifid_stall   = 1'b1;
                    idex_stall   = 1'b1;
                    exmem_bubble = 1'b1;
                    if (md_cnt_q == MD_LAST) begin
                        md_err_d = 1'b1;
                        state_d  = MD_ABORT;
                    end else begin
                        md_cnt_d = md_cnt_q + 1'b1;
                    end
                end
            end
            MD_ABORT: begin
                // Drop the stuck mul/div: bubble EX/MEM and flush ID/EX while the
                // front end holds; idex_flush takes precedence over idex_stall.
                pc_stall     = 1'b1;
                ifid_stall   = 1'b1;
                idex_flush   = 1'b1;
                exmem_bubble = 1'b1;
                state_d      = RUN;
                md_cnt_d     = '0;
            end
            default: begin
                state_d  = RUN;
                md_cnt_d = '0;
            end
        endcase

        if (reset) begin
            pc_stall     = 1'b0;
            ifid_stall   = 1'b0;
            idex_stall   = 1'b0;
            ifid_flush   = 1'b0;
            idex_flush   = 1'b0;
            exmem_bubble = 1'b0;
            md_start     = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (pc_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        flush_cnt_d = flush_cnt_q;
        if (ifid_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            md_cnt_q    <= '0;
            md_err_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            md_err_q    <= md_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.pc_stall     = pc_stall;
    assign bus.ifid_stall   = ifid_stall;
    assign bus.idex_stall   = idex_stall;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_flush   = idex_flush;
    assign bus.exmem_bubble = exmem_bubble;
    assign bus.md_start     = md_start;
    assign bus.md_err       = md_err_q;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.flush_cnt    = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MD_TIMEOUT=8, CNT_W=4 so the counters
// reach saturation quickly). Output vector order:
// {pc_stall, ifid_stall, idex_stall, ifid_flush, idex_flush, exmem_bubble, md_start}
module tb_pipe_hazard_ctrl;
    localparam int unsigned CW = 4;

    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_LU   = 7'b1100100;
    localparam logic [6:0] O_RED  = 7'b0001100;
    localparam logic [6:0] O_MDS  = 7'b1110011;
    localparam logic [6:0] O_MDW  = 7'b1110010;
    localparam logic [6:0] O_ABT  = 7'b1100110;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;
    logic [6:0] outs;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_hazard_ctrl #(.MD_TIMEOUT(8), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign outs = {bus.pc_stall, bus.ifid_stall, bus.idex_stall, bus.ifid_flush,
                   bus.idex_flush, bus.exmem_bubble, bus.md_start};

    typedef struct {
        string      name;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       redir;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic [4:0] rd, input logic mr,
                         input logic redir, input logic mdv, input logic done);
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_use_rs1  = u1;
        bus.id_use_rs2  = u2;
        bus.ex_rd       = rd;
        bus.ex_memread  = mr;
        bus.ex_redirect = redir;
        bus.ex_md_valid = mdv;
        bus.md_done     = done;
    endtask

    // Called just after a falling edge with inputs already driven: compares the
    // combinational outputs, then crosses one rising edge and updates the
    // saturating counter model from the expected outputs.
    task automatic step(input string name, input logic [6:0] exp);
        #1;
        check(name, 32'(outs), 32'(exp));
        @(posedge clk);
        if (reset) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (exp[6] && m_stall != 15) m_stall++;
            if (exp[3] && m_flush != 15) m_flush++;
        end
        @(negedge clk);
    endtask

    task automatic check_cnts(input string name);
        check({name, "_stall_cnt"}, 32'(bus.stall_cnt), m_stall);
        check({name, "_flush_cnt"}, 32'(bus.flush_cnt), m_flush);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"idle",        5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, O_NONE};
        vecs[1] = '{"lu_rs1",      5'd5,  5'd1, 1'b1, 1'b1, 5'd5,  1'b1, 1'b0, O_LU};
        vecs[2] = '{"load_rd0",    5'd0,  5'd0, 1'b1, 1'b1, 5'd0,  1'b1, 1'b0, O_NONE};
        vecs[3] = '{"rs1_unused",  5'd5,  5'd3, 1'b0, 1'b1, 5'd5,  1'b1, 1'b0, O_NONE};
        vecs[4] = '{"lu_rs2",      5'd3,  5'd5, 1'b0, 1'b1, 5'd5,  1'b1, 1'b0, O_LU};
        vecs[5] = '{"no_load",     5'd5,  5'd5, 1'b1, 1'b1, 5'd5,  1'b0, 1'b0, O_NONE};
        vecs[6] = '{"redir_lu",    5'd5,  5'd0, 1'b1, 1'b0, 5'd5,  1'b1, 1'b1, O_RED};
        vecs[7] = '{"redir_only",  5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, O_RED};
        vecs[8] = '{"lu_x31",      5'd31, 5'd2, 1'b1, 1'b0, 5'd31, 1'b1, 1'b0, O_LU};

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        step("rst0", O_NONE);
        step("rst1", O_NONE);
        check("rst_md_err", 32'(bus.md_err), 0);
        check_cnts("rst");
        reset = 1'b0;

        // lw x5 in EX, add x6,x5,x1 in ID: one bubble, then the hazard is gone.
        drive(5, 1, 1, 1, 5, 1, 0, 0, 0);
        step("t1_lu", O_LU);
        check("t1_stall_cnt", 32'(bus.stall_cnt), 1);
        drive(6, 1, 1, 1, 6, 0, 0, 0, 0);
        step("t1_after", O_NONE);

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].rd,
                  vecs[i].mr, vecs[i].redir, 0, 0);
            step(vecs[i].name, vecs[i].exp);
        end
        check_cnts("table");

        // mul/div with md_done 4 cycles after md_start; done in the start cycle is ignored.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step("md_start", O_MDS);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("md_w1", O_MDW);
        drive(5, 0, 1, 0, 5, 1, 1, 1, 0);
        step("md_w2_ign", O_MDW);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("md_w3", O_MDW);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step("md_done", O_NONE);
        // Back-to-back: next mul/div starts immediately, done after 1 cycle.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("md2_start", O_MDS);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("md2_done", O_NONE);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("run_done_ign", O_NONE);
        check("md_err_clean", 32'(bus.md_err), 0);
        check_cnts("md");

        // Timeout: 1 start + 7 wait cycles stalled, then 1 abort cycle.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("to_start", O_MDS);
        for (int i = 0; i < 6; i++) step($sformatf("to_w%0d", i + 1), O_MDW);
        #1;
        check("to_err_pre", 32'(bus.md_err), 0);
        step("to_last", O_MDW);
        check("to_err_set", 32'(bus.md_err), 1);
        drive(0, 0, 0, 0, 0, 0, 1, 1, 1);
        step("to_abort", O_ABT);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("to_run", O_NONE);
        check("cnt_sat", 32'(bus.stall_cnt), 15);
        check_cnts("to");
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("to_redir", O_RED);
        check("md_err_sticky", 32'(bus.md_err), 1);

        // Reset asserted during the 2nd MD_WAIT cycle.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("r_start", O_MDS);
        step("r_w1", O_MDW);
        reset = 1'b1;
        step("r_in_reset", O_NONE);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("r_md_err", 32'(bus.md_err), 0);
        check_cnts("r");
        step("r_run", O_NONE);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("r_redir", O_RED);
        check_cnts("r_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
